instr_decode_queue: RTL

Registered, parametrised successor to the combinational instruction decoder: accepts raw 32-bit MIPS words with their PC over a valid/ready handshake. It decodes each word into the 31-instruction one-hot code plus an illegal flag, and buffers decoded entries in a DEPTH-entry FIFO for the execute stage. It sits between instruction fetch and execute, and decouples fetch stalls from execute stalls. Flush support discards in-flight decodes on branch/jump redirect.

---
 rtl/instr_decode_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instr_decode_queue.sv
// MIPS32 instruction decoder feeding a DEPTH-entry FIFO of {one-hot code, illegal, word, pc}.
// Optional illegal-encoding counter enabled by defining DECODE_ILLEGAL_CNT_EN.
module instr_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_code,
    output logic                       out_illegal,
    output logic [31:0]                out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   dec_code;
    logic          dec_illegal;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          push, pop;

    logic [31:0]     code_mem  [DEPTH];
    logic            ill_mem   [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];

    // Funct is only consulted for SPECIAL (opcode 000000).
    always_comb begin
        dec_code = '0;
        case (in_instr[31:26])
            6'h00: begin
                case (in_instr[5:0])
                    6'h20: dec_code[0]  = 1'b1;
                    6'h21: dec_code[1]  = 1'b1;
                    6'h22: dec_code[2]  = 1'b1;
                    6'h23: dec_code[3]  = 1'b1;
                    6'h24: dec_code[4]  = 1'b1;
                    6'h25: dec_code[5]  = 1'b1;
                    6'h26: dec_code[6]  = 1'b1;
                    6'h27: dec_code[7]  = 1'b1;
                    6'h2A: dec_code[8]  = 1'b1;
                    6'h2B: dec_code[9]  = 1'b1;
                    6'h00: dec_code[10] = 1'b1;
                    6'h02: dec_code[11] = 1'b1;
                    6'h03: dec_code[12] = 1'b1;
                    6'h04: dec_code[13] = 1'b1;
                    6'h06: dec_code[14] = 1'b1;
                    6'h07: dec_code[15] = 1'b1;
                    6'h08: dec_code[16] = 1'b1;
                    default: dec_code = '0;
                endcase
            end
            6'h08: dec_code[17] = 1'b1;
            6'h09: dec_code[18] = 1'b1;
            6'h0C: dec_code[19] = 1'b1;
            6'h0D: dec_code[20] = 1'b1;
            6'h0E: dec_code[21] = 1'b1;
            6'h23: dec_code[22] = 1'b1;
            6'h2B: dec_code[23] = 1'b1;
            6'h04: dec_code[24] = 1'b1;
            6'h05: dec_code[25] = 1'b1;
            6'h0A: dec_code[26] = 1'b1;
            6'h0B: dec_code[27] = 1'b1;
            6'h0F: dec_code[28] = 1'b1;
            6'h02: dec_code[29] = 1'b1;
            6'h03: dec_code[30] = 1'b1;
            default: dec_code = '0;
        endcase
    end

    assign dec_illegal = (dec_code == '0);

    assign in_ready  = (level_reg != LW'(DEPTH));
    assign out_valid = (level_reg != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign level     = level_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      level_reg <= level_reg + 1'b1;
            else if (pop && !push) level_reg <= level_reg - 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    code_mem[gi]  <= '0;
                    ill_mem[gi]   <= 1'b0;
                    instr_mem[gi] <= '0;
                    pc_mem[gi]    <= '0;
                end else if (push && (wr_ptr_reg == AW'(gi))) begin
                    code_mem[gi]  <= dec_code;
                    ill_mem[gi]   <= dec_illegal;
                    instr_mem[gi] <= in_instr;
                    pc_mem[gi]    <= in_pc;
                end
            end
        end
    endgenerate

    // Head fields are read straight from the entry registers, so they hold while stalled.
    assign out_code    = code_mem[rd_ptr_reg];
    assign out_illegal = ill_mem[rd_ptr_reg];
    assign out_instr   = instr_mem[rd_ptr_reg];
    assign out_pc      = pc_mem[rd_ptr_reg];

`ifdef DECODE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt_reg <= '0;
        else if (push && dec_illegal && (illegal_cnt_reg != 16'hFFFF))
            illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
    end

    assign illegal_cnt = illegal_cnt_reg;
`else
    assign illegal_cnt = '0;
`endif

endmodule
